// File: rtl/instruction_memory.sv
// instruction_memory: program store with 1-cycle registered fetch in RUN and a byte-serial LOAD port.
// Optional LOAD_CHECKSUM_EN adds prog_checksum, the running 8-bit sum of accepted load bytes.
module instruction_memory #(
  parameter int DEPTH = 256,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [7:0]        read_address,
  output logic [DATA_W-1:0] instruction,
  output logic              instruction_valid,
  input  logic              prog_enable,
  input  logic              prog_strobe,
  input  logic [DATA_W-1:0] prog_data,
  output logic [8:0]        prog_count,
  output logic              prog_full,
  output logic              loading
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [7:0]        prog_checksum
`endif
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  typedef enum logic {S_RUN, S_LOAD} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] r_instr, w_rd;
  logic r_valid;
  logic [8:0] r_count;
  logic w_enter, w_fetch, w_wr;
  always_comb begin
    w_next = prog_enable ? S_LOAD : S_RUN;
    w_enter = r_state == S_RUN && prog_enable;
    w_fetch = r_state == S_RUN && !prog_enable;
    w_wr = !clear && r_state == S_LOAD && prog_strobe && r_count < DEPTH_W;
    w_rd = {1'b0, read_address} < DEPTH_W ? r_mem[read_address[AW-1:0]] : '0;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= S_RUN;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      r_instr <= w_fetch ? w_rd : '0;
      r_valid <= w_fetch;
      r_count <= w_enter ? 9'd0 : w_wr ? r_count + 9'd1 : r_count;
    end
  end
  // Contents survive clear; only accepted LOAD strobes change them.
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_count[AW-1:0]] <= prog_data;
  end
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] r_sum;
  always_ff @(posedge clock) begin
    if (clear || w_enter) r_sum <= '0;
    else if (w_wr) r_sum <= r_sum + prog_data[7:0];
  end
  assign prog_checksum = r_sum;
`endif
  assign instruction = r_instr;
  assign instruction_valid = r_valid;
  assign prog_count = r_count;
  assign prog_full = r_count == DEPTH_W;
  assign loading = r_state == S_LOAD;
endmodule

// File: doc/instruction_memory.md
Name: instruction_memory

Overview:
- Program store that answers the processor's instruction fetches: it takes the processor's `read_address` and returns the 8-bit `instruction` at that address.
- It also has a byte-serial load port, so a program can be written in from switches or a host before the processor runs.
- Placed at top level beside the processor, on the same clock as the processor core.
- Two modes: RUN (serve fetches) and LOAD (accept program bytes).

Parameters:
- DEPTH, 256, number of instruction words; legal range 2..256.
- DATA_W, 8, instruction word width.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- clear  input  1  synchronous active-high reset.
- read_address  input  8  fetch address driven by the processor.
- instruction  output  DATA_W  fetched word, registered.
- instruction_valid  output  1  high when `instruction` holds the word for the previous cycle's `read_address`.
- prog_enable  input  1  level; high requests LOAD mode.
- prog_strobe  input  1  one byte written per cycle that it is high in LOAD.
- prog_data  input  DATA_W  byte to write.
- prog_count  output  9  number of words written since entering LOAD.
- prog_full  output  1  high once `prog_count` equals DEPTH.
- loading  output  1  high while in LOAD.

Behaviour:
- Storage:
  - DEPTH x DATA_W array, initialised to all zero at power-up.
  - `clear` does NOT modify stored contents.
- Reset (`clear` high at an edge):
  - state = RUN.
  - `instruction` = 0, `instruction_valid` = 0.
  - `prog_count` = 0, `prog_full` = 0, `loading` = 0.
  - Write pointer = 0.
  - Reset overrides every other input in that cycle, including mid-LOAD; a strobe in the reset cycle is discarded.
- RUN state:
  - Every cycle: `instruction` <= mem[read_address]; `instruction_valid` <= 1.
  - Latency is exactly 1 cycle from address to data.
  - If `read_address` >= DEPTH, `instruction` <= 0 (still valid).
  - `prog_strobe` is ignored.
  - `prog_enable` sampled high: next state = LOAD. At that edge:
    - `instruction` <= 0, `instruction_valid` <= 0, `loading` <= 1.
    - Write pointer <= 0, `prog_count` <= 0, `prog_full` <= 0.
    - A strobe in this same cycle is ignored.
- LOAD state:
  - `instruction` held at 0, `instruction_valid` held at 0.
  - Cycle with `prog_strobe`=1 and pointer < DEPTH:
    - mem[pointer] <= `prog_data`.
    - Pointer and `prog_count` increment.
    - `prog_full` <= 1 when the new count equals DEPTH.
  - Strobe with pointer = DEPTH: ignored. No wrap; count stays at DEPTH.
  - `prog_enable` sampled low: next state = RUN, `loading` <= 0.
    - A strobe in that same cycle is still written (the last byte is accepted).
    - First valid fetch: `instruction_valid`=1 one edge after the first RUN cycle.
    - `prog_count`/`prog_full` hold their final values until the next LOAD entry or reset.
- Simultaneous write and fetch: fetches occur only in RUN and writes only in LOAD, so there is no read/write collision.
- Unused address bits above log2(DEPTH) participate in the out-of-range check only.

Optional Feature:
- Macro: `LOAD_CHECKSUM_EN`.
- Defined:
  - Extra output `prog_checksum` (8 bits).
  - Cleared to 0 on reset and on LOAD entry.
  - On each accepted write: `prog_checksum` <= (`prog_checksum` + `prog_data`[7:0]) mod 256. Rejected strobes (full) do not contribute.
  - Holds its value in RUN.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then RUN with memory all zero; `read_address`=8'h05 -> next edge `instruction`=8'h00, `instruction_valid`=1; during reset, `instruction_valid`=0.
- LOAD 4 bytes 8'h41, 8'h82, 8'hC3, 8'h04 on consecutive strobes, drop `prog_enable` -> `prog_count`=4. Then fetch addresses 0,1,2,3 back-to-back -> 8'h41, 8'h82, 8'hC3, 8'h04, each one cycle after its address. With `LOAD_CHECKSUM_EN`, `prog_checksum`=8'h8A.
- DEPTH=4: issue 6 strobes (data 1..6) -> `prog_full`=1 after 4th, `prog_count`=4. Fetch 0..3 -> 1,2,3,4. Fetch address 8'h07 -> 8'h00, `instruction_valid`=1.
- Strobe in the same cycle `prog_enable` falls -> that byte is stored at the next pointer. Strobe in the LOAD-entry cycle -> not stored, `prog_count` unchanged at 0.
- `clear` asserted after 2 of 5 load bytes -> state RUN, `loading`=0, `prog_count`=0. Fetch address 0 and 1 return the 2 bytes already written (contents preserved).
- Re-enter LOAD after a completed load -> `prog_count`/`prog_full` reset to 0. New bytes overwrite from address 0; untouched higher addresses keep their old values.
